// File: rtl/mem_access_unit.sv
`default_nettype none
// mem_access_unit: load/store sequencer onto a single-port, synchronous-read data memory (rev 1.0).
// Optional MAU_RANGE_CHECK_EN: misaligned/out-of-range addresses return resp_err instead of accessing memory.
module mem_access_unit #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_st,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_rd,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [3:0]        resp_rd,
  output logic              resp_err,
  output logic              mem_ena,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [DATA_W-1:0] mem_dina,
  input  logic [DATA_W-1:0] mem_douta
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

  state_t            state_q;
  logic              valid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [3:0]        rd_q;
  logic              accept;
  logic              needs_resp;

  assign req_ready  = (state_q == IDLE) && !rsta;
  assign accept     = req_valid && req_ready;
  assign mem_addra  = req_addr[ADDR_W+1:2];
  assign mem_dina   = req_wdata;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_rd    = rd_q;

`ifdef MAU_RANGE_CHECK_EN
  logic addr_err;
  logic err_pend_q;
  logic err_q;

  assign addr_err   = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_W+2] != '0);
  assign mem_ena    = accept && !addr_err;
  assign mem_wea    = accept && req_is_st && !addr_err;
  assign needs_resp = !req_is_st || addr_err;
  assign resp_err   = err_q;
`else
  logic unused_addr_bits;

  // Byte offset and high address bits are dropped so the word address wraps.
  assign unused_addr_bits = ^{req_addr[1:0], req_addr[31:ADDR_W+2]};
  assign mem_ena    = accept;
  assign mem_wea    = accept && req_is_st;
  assign needs_resp = !req_is_st;
  assign resp_err   = 1'b0;
`endif

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      rdata_q <= '0;
      rd_q    <= '0;
`ifdef MAU_RANGE_CHECK_EN
      err_pend_q <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          // Good stores complete in memory at this edge; only loads and errors need a response.
          if (accept && needs_resp) begin
            rd_q    <= req_rd;
            state_q <= RD_WAIT;
`ifdef MAU_RANGE_CHECK_EN
            err_pend_q <= addr_err;
`endif
          end
        end
        RD_WAIT: begin
`ifdef MAU_RANGE_CHECK_EN
          rdata_q <= err_pend_q ? '0 : mem_douta;
          err_q   <= err_pend_q;
`else
          rdata_q <= mem_douta;
`endif
          valid_q <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
`ifdef MAU_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// tb_mem_access_unit: directed and randomized checks against a word-array reference model.
module tb_mem_access_unit;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid, req_ready, req_is_st;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [3:0]        req_rd;
  logic              resp_valid, resp_ready, resp_err;
  logic [DATA_W-1:0] resp_rdata;
  logic [3:0]        resp_rd;
  logic              mem_ena, mem_wea;
  logic [ADDR_W-1:0] mem_addra;
  logic [DATA_W-1:0] mem_dina, mem_douta;

  logic [DATA_W-1:0] ram     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int n_checks = 0;
  int n_errors = 0;

  mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clka(clk), .rsta(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_st(req_is_st),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_rd(resp_rd), .resp_err(resp_err),
    .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra),
    .mem_dina(mem_dina), .mem_douta(mem_douta)
  );

  always #5 clk = ~clk;

  // Synchronous-read single-port RAM behind the unit.
  always @(posedge clk) begin
    if (mem_ena) begin
      if (mem_wea) ram[mem_addra] <= mem_dina;
      mem_douta <= ram[mem_addra];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 32'd4) % DEPTH);
  endfunction

  function automatic logic [31:0] rand_addr();
`ifdef MAU_RANGE_CHECK_EN
    return 32'($urandom_range(0, 15)) << 2;
`else
    return ($urandom & 32'hFFFF_FE00) | (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'h3);
`endif
  endfunction

  // All tasks start and end in the low clock phase; checks sample 1ns after driving.
  task automatic idle();
    req_valid = 1'b0;
    req_is_st = 1'b0;
    #1;
    check("idle_ena",   64'(mem_ena),    64'(0));
    check("idle_valid", 64'(resp_valid), 64'(0));
    check("idle_ready", 64'(req_ready),  64'(1));
    @(negedge clk);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [DATA_W-1:0] data);
    req_valid = 1'b1;
    req_is_st = 1'b1;
    req_addr  = addr;
    req_wdata = data;
    req_rd    = 4'($urandom);
    #1;
    check("st_ready",  64'(req_ready),  64'(1));
    check("st_ena",    64'(mem_ena),    64'(1));
    check("st_wea",    64'(mem_wea),    64'(1));
    check("st_addr",   64'(mem_addra),  64'(word_of(addr)));
    check("st_noresp", 64'(resp_valid), 64'(0));
    ref_mem[word_of(addr)] = data;
    @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [3:0] tag, input int stall);
    logic [DATA_W-1:0] exp;
    req_valid  = 1'b1;
    req_is_st  = 1'b0;
    req_addr   = addr;
    req_rd     = tag;
    req_wdata  = $urandom;
    resp_ready = 1'b0;
    exp = ref_mem[word_of(addr)];
    #1;
    check("ld_ready", 64'(req_ready), 64'(1));
    check("ld_ena",   64'(mem_ena),   64'(1));
    check("ld_wea",   64'(mem_wea),   64'(0));
    check("ld_addr",  64'(mem_addra), 64'(word_of(addr)));
    @(negedge clk);
    // Requests presented while busy must be ignored.
    req_is_st = 1'($urandom);
    req_addr  = rand_addr();
    #1;
    check("wait_ready", 64'(req_ready),  64'(0));
    check("wait_ena",   64'(mem_ena),    64'(0));
    check("wait_valid", 64'(resp_valid), 64'(0));
    @(negedge clk);
    for (int i = 0; i <= stall; i++) begin
      resp_ready = (i == stall);
      #1;
      check("resp_valid", 64'(resp_valid), 64'(1));
      check("resp_rdata", 64'(resp_rdata), 64'(exp));
      check("resp_rd",    64'(resp_rd),    64'(tag));
      check("resp_err",   64'(resp_err),   64'(0));
      check("resp_busy",  64'(req_ready),  64'(0));
      check("resp_ena",   64'(mem_ena),    64'(0));
      @(negedge clk);
    end
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    #1;
    check("ld_done_valid", 64'(resp_valid), 64'(0));
    check("ld_done_ready", 64'(req_ready),  64'(1));
  endtask

`ifdef MAU_RANGE_CHECK_EN
  task automatic do_err(input logic [31:0] addr, input logic is_st, input logic [3:0] tag);
    req_valid  = 1'b1;
    req_is_st  = is_st;
    req_addr   = addr;
    req_rd     = tag;
    req_wdata  = $urandom;
    resp_ready = 1'b0;
    #1;
    check("err_ready", 64'(req_ready), 64'(1));
    check("err_ena",   64'(mem_ena),   64'(0));
    check("err_wea",   64'(mem_wea),   64'(0));
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("err_wait_valid", 64'(resp_valid), 64'(0));
    check("err_wait_ena",   64'(mem_ena),    64'(0));
    @(negedge clk);
    resp_ready = 1'b1;
    #1;
    check("err_valid", 64'(resp_valid), 64'(1));
    check("err_flag",  64'(resp_err),   64'(1));
    check("err_rdata", 64'(resp_rdata), 64'(0));
    check("err_rd",    64'(resp_rd),    64'(tag));
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    check("err_done_valid", 64'(resp_valid), 64'(0));
    check("err_done_ready", 64'(req_ready),  64'(1));
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = '0;
      ref_mem[i] = '0;
    end
    // Drive a live store request during reset: it must be gated off.
    req_valid  = 1'b1;
    req_is_st  = 1'b1;
    req_addr   = 32'h4;
    req_wdata  = 32'h1234_5678;
    req_rd     = 4'd0;
    resp_ready = 1'b0;
    rst        = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", 64'(req_ready),  64'(0));
    check("rst_valid", 64'(resp_valid), 64'(0));
    check("rst_rdata", 64'(resp_rdata), 64'(0));
    check("rst_rd",    64'(resp_rd),    64'(0));
    check("rst_err",   64'(resp_err),   64'(0));
    check("rst_ena",   64'(mem_ena),    64'(0));
    check("rst_wea",   64'(mem_wea),    64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Store then load the same word, accepted in the first cycle after reset.
    do_store(32'h0000_0010, 32'hDEAD_BEEF);
    do_load(32'h0000_0010, 4'd5, 0);
    @(negedge clk);

    // Four back-to-back stores.
    do_store(32'h0, 32'h1111_0000);
    do_store(32'h4, 32'h2222_0001);
    do_store(32'h8, 32'h3333_0002);
    do_store(32'hC, 32'h4444_0003);
    idle();

    // Load with response back-pressure for five cycles.
    do_load(32'h8, 4'd9, 5);
    @(negedge clk);

    // Reset while the load sits in RD_WAIT: the load is discarded.
    req_valid = 1'b1;
    req_is_st = 1'b0;
    req_addr  = 32'h4;
    req_rd    = 4'd3;
    #1;
    check("rd_rst_ena", 64'(mem_ena), 64'(1));
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b1;
    #1;
    check("rd_rst_ready", 64'(req_ready),  64'(0));
    check("rd_rst_valid", 64'(resp_valid), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_ready", 64'(req_ready), 64'(1));
    for (int i = 0; i < 4; i++) begin
      check("rel_noresp", 64'(resp_valid), 64'(0));
      @(negedge clk);
      #1;
    end

`ifdef MAU_RANGE_CHECK_EN
    do_err(32'h0000_0202, 1'b0, 4'd7);
    @(negedge clk);
    do_err(32'h0000_0200, 1'b1, 4'd2);
    @(negedge clk);
    do_load(32'h0, 4'd1, 0);
    @(negedge clk);
`else
    do_store(32'h0000_0200, 32'hCAFE_F00D);
    idle();
    do_load(32'h0000_0000, 4'd6, 1);
    @(negedge clk);
`endif

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 1) == 1)
        do_store(rand_addr(), $urandom);
      else
        do_load(rand_addr(), 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
